// File: rtl/m1_image_loader.sv
// m1_image_loader
//   Writer side of the M1 input-image memory. Packs a valid/ready pixel stream
//   into PIXELS_PER_WORD-wide M1 words (lane 0 in the low bits) and writes whole
//   frames into two ping-pong buffers. Each committed frame is announced with a
//   one-cycle frame_ready pulse and its buffer select. The buffer then stays
//   locked until the consumer returns buffer_release.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_data    pixel stream, in_last marks the final pixel of a frame
//   in_ready            loader accepts a pixel this cycle (registered state only)
//   M1_WriteBus         packed word, unfilled lanes zero
//   M1_WriteAddress     {buffer select, word index}
//   M1_WriteEnable      one-cycle write strobe
//   frame_ready         one-cycle pulse when a frame is committed
//   frame_base_offset   buffer select of the committed frame (with frame_ready)
//   buffer_release      one-cycle pulse freeing the oldest full buffer
//   frame_err           one-cycle pulse with frame_ready when frame length was wrong
module m1_image_loader #(
   parameter int unsigned PIXEL_W         = 8,
   parameter int unsigned PIXELS_PER_WORD = 4,
   parameter int unsigned FRAME_WORDS     = 4096,
   parameter int unsigned ADDR_W          = 13
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               in_valid,
   input  logic [PIXEL_W-1:0]                 in_data,
   input  logic                               in_last,
   output logic                               in_ready,
   output logic [PIXEL_W*PIXELS_PER_WORD-1:0] M1_WriteBus,
   output logic [ADDR_W-1:0]                  M1_WriteAddress,
   output logic                               M1_WriteEnable,
   output logic                               frame_ready,
   output logic                               frame_base_offset,
   input  logic                               buffer_release,
   output logic                               frame_err
);

   localparam int unsigned WORD_W = PIXEL_W * PIXELS_PER_WORD;
   localparam int unsigned IDX_W  = ADDR_W - 1;
   localparam int unsigned LANE_W = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIXELS_PER_WORD - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_rst_done;
   logic                r_wr_sel;
   logic                r_rd_sel;
   logic [1:0]          r_buf_full;
   logic [LANE_W-1:0]   r_lane;
   logic [IDX_W-1:0]    r_word_idx;
   logic [WORD_W-1:0]   r_pack;
   logic                r_err;
   logic [WORD_W-1:0]   r_bus;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;

   logic                w_accept;
   logic                w_last_word;
   logic                w_last_lane;
   logic                w_word_done;
   logic                w_frame_end;
   logic                w_frame_ok;
   logic                w_commit;
   logic                w_release;
   logic [1:0]          w_set_mask;
   logic [1:0]          w_clr_mask;
   logic [WORD_W-1:0]   w_word_nxt;

   // r_rst_done keeps in_ready low while reset is held and on the first cycle after.
   assign in_ready = r_rst_done &
                     (((r_state == S_IDLE) & ~r_buf_full[r_wr_sel]) | (r_state == S_FILL));
   assign w_accept = in_valid & in_ready;

   assign w_last_word = (r_word_idx == LAST_IDX);
   assign w_last_lane = (r_lane == LAST_LANE);
   assign w_word_done = in_last | w_last_lane;
   assign w_frame_end = in_last | (w_last_lane & w_last_word);
   assign w_frame_ok  = in_last & w_last_lane & w_last_word;

   assign w_commit   = (r_state == S_COMMIT);
   // A release with no full buffer is ignored, so the read pointer never runs ahead.
   assign w_release  = buffer_release & (|r_buf_full);
   assign w_set_mask = w_commit  ? (2'b01 << r_wr_sel) : 2'b00;
   assign w_clr_mask = w_release ? (2'b01 << r_rd_sel) : 2'b00;

   // Lane 0 starts from zero so lanes not reached before in_last stay zero-padded.
   always_comb begin
      w_word_nxt = (r_lane == '0) ? '0 : r_pack;
      w_word_nxt[int'(r_lane) * PIXEL_W +: PIXEL_W] = in_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt       = r_state;
      frame_ready       = 1'b0;
      frame_base_offset = 1'b0;
      frame_err         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = w_frame_end ? S_COMMIT : S_FILL;
         end
         S_FILL: begin
            if (w_accept && w_frame_end) w_state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            frame_ready       = 1'b1;
            frame_base_offset = r_wr_sel;
            frame_err         = r_err;
            w_state_nxt       = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rst_done <= 1'b0;
         r_wr_sel   <= 1'b0;
         r_rd_sel   <= 1'b0;
         r_buf_full <= '0;
         r_lane     <= '0;
         r_word_idx <= '0;
         r_pack     <= '0;
         r_err      <= 1'b0;
         r_bus      <= '0;
         r_addr     <= '0;
         r_we       <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
         r_we       <= 1'b0;
         // Release clears after commit sets, so a release on the buffer being
         // committed only wins if that buffer was already marked full.
         r_buf_full <= (r_buf_full | w_set_mask) & ~w_clr_mask;
         if (w_release) r_rd_sel <= ~r_rd_sel;

         if (w_commit) begin
            r_wr_sel   <= ~r_wr_sel;
            r_word_idx <= '0;
            r_lane     <= '0;
         end else if (w_accept) begin
            r_pack <= w_word_nxt;
            if (w_word_done) begin
               r_we       <= 1'b1;
               r_bus      <= w_word_nxt;
               r_addr     <= {r_wr_sel, r_word_idx};
               r_lane     <= '0;
               r_word_idx <= r_word_idx + 1'b1;
            end else begin
               r_lane <= r_lane + 1'b1;
            end
            if (w_frame_end) r_err <= ~w_frame_ok;
         end
      end
   end

   assign M1_WriteBus     = r_bus;
   assign M1_WriteAddress = r_addr;
   assign M1_WriteEnable  = r_we;

endmodule

// File: tb/tb_m1_image_loader.sv
// tb_m1_image_loader
//   Directed stimulus for m1_image_loader with a small frame (4 words of 4
//   pixels). A frame-level model (pixel counters, buffer occupancy count) gives
//   the expected outputs every cycle; literal expectations pin selected writes
//   and commits.
`timescale 1ns/1ps
module tb_m1_image_loader;

   localparam int unsigned PW       = 8;
   localparam int unsigned PPW      = 4;
   localparam int unsigned FW       = 4;
   localparam int unsigned AW       = 3;
   localparam int unsigned FRAME_PX = PPW * FW;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [PW-1:0]     in_data = '0;
   logic              in_last = 1'b0;
   logic              buffer_release = 1'b0;
   logic              in_ready;
   logic [PW*PPW-1:0] M1_WriteBus;
   logic [AW-1:0]     M1_WriteAddress;
   logic              M1_WriteEnable;
   logic              frame_ready;
   logic              frame_base_offset;
   logic              frame_err;

   int checks   = 0;
   int failures = 0;

   m1_image_loader #(
      .PIXEL_W(PW),
      .PIXELS_PER_WORD(PPW),
      .FRAME_WORDS(FW),
      .ADDR_W(AW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_last(in_last),
      .in_ready(in_ready),
      .M1_WriteBus(M1_WriteBus),
      .M1_WriteAddress(M1_WriteAddress),
      .M1_WriteEnable(M1_WriteEnable),
      .frame_ready(frame_ready),
      .frame_base_offset(frame_base_offset),
      .buffer_release(buffer_release),
      .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   // Model state: pixels so far in the frame, lane contents, full-buffer count,
   // buffer being written, and expected outputs for the current cycle.
   int            m_count = 0;
   int            m_pix   = 0;
   logic          m_wr    = 1'b0;
   logic [PW-1:0] m_lane [PPW];
   logic          exp_we = 0, exp_fr = 0, exp_off = 0, exp_err = 0, exp_ready = 0;
   logic [AW-1:0] exp_addr = '0;
   logic [31:0]   exp_bus  = '0;

   logic [AW-1:0] log_addr [$];
   logic [31:0]   log_data [$];
   logic          log_off  [$];
   logic          log_err  [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit acc;
      bit eff;
      int lane;
      int word;
      acc = in_valid && exp_ready;
      eff = buffer_release && (m_count > 0);
      if (exp_fr) begin
         m_count++;
         m_wr = ~m_wr;
      end
      if (eff) m_count--;
      exp_we  = 0;
      exp_fr  = 0;
      exp_off = 0;
      exp_err = 0;
      if (acc) begin
         lane = m_pix % PPW;
         word = m_pix / PPW;
         if (lane == 0) for (int i = 0; i < PPW; i++) m_lane[i] = '0;
         m_lane[lane] = in_data;
         m_pix++;
         if (in_last || lane == PPW - 1) begin
            exp_we   = 1;
            exp_addr = AW'(int'(m_wr) * FW + word);
            exp_bus  = '0;
            for (int i = 0; i < PPW; i++) exp_bus = exp_bus | (32'(m_lane[i]) << (PW * i));
         end
         if (in_last || m_pix == FRAME_PX) begin
            exp_fr  = 1;
            exp_off = m_wr;
            exp_err = !(in_last && m_pix == FRAME_PX);
            m_pix   = 0;
         end
      end
      exp_ready = !exp_fr && (m_count < 2);
   endtask

   always @(negedge clock) begin
      if (reset) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_we", M1_WriteEnable, 0);
         chk("rst_addr", M1_WriteAddress, 0);
         chk("rst_bus", M1_WriteBus, 0);
         chk("rst_frame_ready", frame_ready, 0);
         chk("rst_offset", frame_base_offset, 0);
         chk("rst_frame_err", frame_err, 0);
         m_count = 0; m_pix = 0; m_wr = 0;
         exp_we = 0; exp_fr = 0; exp_off = 0; exp_err = 0; exp_ready = 0;
      end else begin
         chk("in_ready", in_ready, exp_ready);
         chk("write_enable", M1_WriteEnable, exp_we);
         if (exp_we) begin
            chk("write_addr", M1_WriteAddress, exp_addr);
            chk("write_bus", M1_WriteBus, exp_bus);
         end
         chk("frame_ready", frame_ready, exp_fr);
         if (exp_fr) chk("frame_offset", frame_base_offset, exp_off);
         chk("frame_err", frame_err, exp_err);
         if (M1_WriteEnable) begin
            log_addr.push_back(M1_WriteAddress);
            log_data.push_back(M1_WriteBus);
         end
         if (frame_ready) begin
            log_off.push_back(frame_base_offset);
            log_err.push_back(frame_err);
         end
         model_step();
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic send(input logic [PW-1:0] px, input logic last);
      int  n;
      bit  acc;
      n   = 0;
      acc = 0;
      in_valid = 1'b1;
      in_data  = px;
      in_last  = last;
      while (!acc && n < 100) begin
         @(negedge clock);
         acc = in_ready;
         @(posedge clock);
         #1;
         buffer_release = 1'b0;
         n++;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_accepted required=accepted px=%0h", px);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
         buffer_release = 1'b0;
      end
   endtask

   task automatic chk_w(input int idx, input logic [AW-1:0] addr, input logic [31:0] data);
      if (idx < log_data.size()) begin
         chk($sformatf("lit_addr%0d", idx), log_addr[idx], addr);
         chk($sformatf("lit_data%0d", idx), log_data[idx], data);
      end else begin
         chk($sformatf("lit_missing%0d", idx), log_data.size(), idx + 1);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_offs [7];
      logic exp_errs [7];
      exp_offs = '{0, 1, 0, 1, 0, 1, 0};
      exp_errs = '{0, 0, 1, 1, 1, 0, 0};

      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Two full frames back to back, no release.
      for (int i = 0; i < 32; i++) send(PW'(i), i == 15 || i == 31);
      idle(2);

      // Both buffers full: pixel offered but held off.
      in_valid = 1'b1;
      in_data  = 8'h20;
      repeat (4) begin @(posedge clock); #1; end
      chk("bp_in_ready", in_ready, 0);

      // Release, then a short frame ending on pixel 5.
      buffer_release = 1'b1;
      for (int i = 0; i < 6; i++) send(8'h20 + PW'(i), i == 5);
      idle(2);

      // Free both buffers, then a release with nothing full.
      buffer_release = 1'b1; idle(1);
      buffer_release = 1'b1; idle(1);
      buffer_release = 1'b1; idle(2);

      // 20 pixels: long frame, remainder closes a short frame; releases on commits.
      for (int i = 0; i < 16; i++) send(8'h40 + PW'(i), 1'b0);
      buffer_release = 1'b1;
      for (int i = 0; i < 4; i++) send(8'h50 + PW'(i), i == 3);
      buffer_release = 1'b1;
      for (int i = 0; i < 16; i++) send(8'h60 + PW'(i), i == 15);

      in_valid = 1'b1;
      in_data  = 8'h70;
      repeat (4) begin @(posedge clock); #1; end
      chk("bp2_in_ready", in_ready, 0);
      buffer_release = 1'b1;
      for (int i = 0; i < 7; i++) send(8'h70 + PW'(i), 1'b0);

      // Reset in the middle of the frame.
      in_valid = 1'b1;
      in_data  = 8'h77;
      reset    = 1'b1;
      #1;
      chk("midrst_we", M1_WriteEnable, 0);
      chk("midrst_frame_ready", frame_ready, 0);
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      for (int i = 0; i < 16; i++) send(8'h80 + PW'(i), i == 15);
      idle(3);

      chk("lit_write_count", log_data.size(), 24);
      chk("lit_frame_count", log_off.size(), 7);
      chk_w(0,  3'd0, 32'h03020100);
      chk_w(3,  3'd3, 32'h0F0E0D0C);
      chk_w(4,  3'd4, 32'h13121110);
      chk_w(7,  3'd7, 32'h1F1E1D1C);
      chk_w(8,  3'd0, 32'h23222120);
      chk_w(9,  3'd1, 32'h00002524);
      chk_w(10, 3'd4, 32'h43424140);
      chk_w(13, 3'd7, 32'h4F4E4D4C);
      chk_w(14, 3'd0, 32'h53525150);
      chk_w(15, 3'd4, 32'h63626160);
      chk_w(19, 3'd0, 32'h73727170);
      chk_w(20, 3'd0, 32'h83828180);
      chk_w(23, 3'd3, 32'h8F8E8D8C);
      for (int i = 0; i < 7; i++) begin
         if (i < log_off.size()) begin
            chk($sformatf("lit_off%0d", i), log_off[i], exp_offs[i]);
            chk($sformatf("lit_err%0d", i), log_err[i], exp_errs[i]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
